// File: rtl/wb_sram_bridge.sv
// Wishbone B4 slave bridging classic and incrementing-burst cycles onto a
// synchronous single-port SRAM whose read data arrives one cycle after the address.
module wb_sram_bridge #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int WORD_AW       = AW - 2,
    parameter int MEM_SIZE_BYTE = 'h8000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       wb_adr_i,
    input  logic [DW-1:0]       wb_dat_i,
    input  logic [DW/8-1:0]     wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [2:0]          wb_cti_i,
    input  logic [1:0]          wb_bte_i,
    output logic [DW-1:0]       wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                sram_ce,
    output logic                sram_we,
    output logic                sram_oe,
    output logic [WORD_AW-1:0]  sram_waddr,
    output logic [DW-1:0]       sram_din,
    output logic [DW/8-1:0]     sram_sel,
    input  logic [DW-1:0]       sram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WACK, S_ERR} state_t;

    state_t             r_state;
    logic               r_ready;
    logic [WORD_AW-1:0] r_bcnt;
    logic [WORD_AW-1:0] r_waddr;
    logic [DW-1:0]      r_din;
    logic [DW/8-1:0]    r_sel;

    logic               w_req;
    logic               w_oor;
    logic               w_burst;
    logic               w_access;
    logic               w_write;
    logic [WORD_AW-1:0] w_adr_word;
    logic [WORD_AW-1:0] w_acc_addr;
    logic [WORD_AW-1:0] w_bcnt_next;

    // r_ready keeps the SRAM idle until one full clock after reset release.
    assign w_req      = r_ready & wb_cyc_i & wb_stb_i;
    assign w_adr_word = wb_adr_i[WORD_AW+1:2];
    assign w_oor      = wb_adr_i >= AW'(MEM_SIZE_BYTE);
    assign w_burst    = (wb_cti_i == 3'b010);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_bcnt_next = r_bcnt + WORD_AW'(1);
        case (wb_bte_i)
            2'b01:   w_bcnt_next = {r_bcnt[WORD_AW-1:2], r_bcnt[1:0] + 2'd1};
            2'b10:   w_bcnt_next = {r_bcnt[WORD_AW-1:3], r_bcnt[2:0] + 3'd1};
            2'b11:   w_bcnt_next = {r_bcnt[WORD_AW-1:4], r_bcnt[3:0] + 4'd1};
            default: w_bcnt_next = r_bcnt + WORD_AW'(1);
        endcase
    end

    always_comb begin
        w_access   = 1'b0;
        w_write    = 1'b0;
        w_acc_addr = r_waddr;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_oor) begin
                    w_access   = 1'b1;
                    w_write    = wb_we_i;
                    w_acc_addr = w_adr_word;
                end
            end
            S_READ: begin
                if (wb_cyc_i && !wb_stb_i) begin
                    // Wait state: re-issue the pending beat so its data stays valid.
                    w_access   = 1'b1;
                    w_acc_addr = r_bcnt;
                end else if (wb_cyc_i && w_burst) begin
                    w_access   = 1'b1;
                    w_acc_addr = w_bcnt_next;
                end
            end
            default: ;
        endcase
    end

    assign sram_ce    = w_access;
    assign sram_we    = w_write;
    assign sram_oe    = w_access & ~w_write;
    assign sram_waddr = w_acc_addr;
    assign sram_din   = w_write ? wb_dat_i : r_din;
    assign sram_sel   = w_write ? wb_sel_i : r_sel;

    assign wb_ack_o = ((r_state == S_READ) & wb_cyc_i & wb_stb_i) |
                      ((r_state == S_WACK) & wb_cyc_i);
    assign wb_err_o = (r_state == S_ERR) & wb_cyc_i;
    assign wb_dat_o = (r_state == S_READ) ? sram_dout : '0;

    // NOTE: sequential state uses non-blocking assignments only; the held SRAM
    // address/data registers drive outputs, so they are reset along with the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_bcnt  <= '0;
            r_waddr <= '0;
            r_din   <= '0;
            r_sel   <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_access) r_waddr <= w_acc_addr;
            if (w_write) begin
                r_din <= wb_dat_i;
                r_sel <= wb_sel_i;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_oor) begin
                            r_state <= S_ERR;
                        end else if (wb_we_i) begin
                            r_state <= S_WACK;
                        end else begin
                            r_state <= S_READ;
                            r_bcnt  <= w_adr_word;
                        end
                    end
                end
                S_READ: begin
                    if (!wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end else if (wb_stb_i) begin
                        if (w_burst) r_bcnt  <= w_bcnt_next;
                        else         r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Table-driven bench for wb_sram_bridge: one record per clock cycle, plus a
// hand-written reset-during-burst sequence.
module tb_wb_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        sram_ce, sram_we, sram_oe;
    logic [29:0] sram_waddr;
    logic [31:0] sram_din, sram_dout;
    logic [3:0]  sram_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_sram_bridge dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe),
        .sram_waddr(sram_waddr), .sram_din(sram_din), .sram_sel(sram_sel),
        .sram_dout(sram_dout)
    );

    // Synchronous SRAM model: registered read data, byte-masked writes.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'h1234_5678;
        sram_dout = '0;
    end
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) mem[sram_waddr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_waddr[7:0]];
            end
        end
    end

    typedef struct {
        logic        cyc, stb, we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        e_ack, e_err, e_ce, e_we;
        logic [29:0] e_waddr;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit cyc, stb, we, input bit [2:0] cti, input bit [1:0] bte,
                                input bit [31:0] adr, dat, input bit [3:0] sel,
                                input bit ack, err, ce, swe, input bit [29:0] wa, input bit [31:0] rd);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.cti = cti; v.bte = bte;
        v.adr = adr; v.dat = dat; v.sel = sel;
        v.e_ack = ack; v.e_err = err; v.e_ce = ce; v.e_we = swe; v.e_waddr = wa; v.e_rd = rd;
        return v;
    endfunction

    function automatic vec_t idle(input bit [29:0] wa);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wa, 0);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_cyc_i = v.cyc; wb_stb_i = v.stb; wb_we_i = v.we;
        wb_cti_i = v.cti; wb_bte_i = v.bte;
        wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ack"}, 32'(wb_ack_o), 0);
        check({tag, " err"}, 32'(wb_err_o), 0);
        check({tag, " ce"},  32'(sram_ce), 0);
        check({tag, " we"},  32'(sram_we), 0);
        check({tag, " oe"},  32'(sram_oe), 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(idle(0));

        vecs.push_back(idle(0));
        // classic read of word 4
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h10, 0, 0, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h10, 0, 0, 1, 0, 0, 0, 4, 'h1234_5678));
        vecs.push_back(idle(4));
        // single write, bytes 1 and 2
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h10, 'hDEAD_BEEF, 'b0110, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h10, 'hDEAD_BEEF, 'b0110, 1, 0, 0, 0, 4, 0));
        vecs.push_back(idle(4));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h10, 0, 0, 0, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h10, 0, 0, 1, 0, 0, 0, 4, 'h12AD_BE78));
        vecs.push_back(idle(4));
        // wrap-4 burst from word 6: 6,7,4,5
        vecs.push_back(mk(1, 1, 0, 2, 1, 'h18, 0, 0, 0, 0, 1, 0, 6, 0));
        vecs.push_back(mk(1, 1, 0, 2, 1, 'h18, 0, 0, 1, 0, 1, 0, 7, 'hA000_0006));
        vecs.push_back(mk(1, 1, 0, 2, 1, 'h18, 0, 0, 1, 0, 1, 0, 4, 'hA000_0007));
        vecs.push_back(mk(1, 1, 0, 2, 1, 'h18, 0, 0, 1, 0, 1, 0, 5, 'h12AD_BE78));
        vecs.push_back(mk(1, 1, 0, 7, 1, 'h18, 0, 0, 1, 0, 0, 0, 5, 'hA000_0005));
        vecs.push_back(idle(5));
        // linear burst from word 8 with two wait states after beat 2
        vecs.push_back(mk(1, 1, 0, 2, 0, 'h20, 0, 0, 0, 0, 1, 0, 8, 0));
        vecs.push_back(mk(1, 1, 0, 2, 0, 'h20, 0, 0, 1, 0, 1, 0, 9, 'hA000_0008));
        vecs.push_back(mk(1, 1, 0, 2, 0, 'h20, 0, 0, 1, 0, 1, 0, 10, 'hA000_0009));
        vecs.push_back(mk(1, 0, 0, 2, 0, 'h20, 0, 0, 0, 0, 1, 0, 10, 0));
        vecs.push_back(mk(1, 0, 0, 2, 0, 'h20, 0, 0, 0, 0, 1, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 7, 0, 'h20, 0, 0, 1, 0, 0, 0, 10, 'hA000_000A));
        vecs.push_back(idle(10));
        // out-of-range read at MEM_SIZE_BYTE
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h8000, 0, 0, 0, 0, 0, 0, 10, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h8000, 0, 0, 0, 1, 0, 0, 10, 0));
        vecs.push_back(idle(10));
        // read aborted by dropping cyc
        vecs.push_back(mk(1, 1, 0, 0, 0, 'h0C, 0, 0, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 'h0C, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(idle(3));
        // out-of-range write
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h8004, 'h55, 'hF, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 'h8004, 'h55, 'hF, 0, 1, 0, 0, 3, 0));
        vecs.push_back(idle(3));
        // wrap-8 from word 15 -> 8
        vecs.push_back(mk(1, 1, 0, 2, 2, 'h3C, 0, 0, 0, 0, 1, 0, 15, 0));
        vecs.push_back(mk(1, 1, 0, 2, 2, 'h3C, 0, 0, 1, 0, 1, 0, 8, 'hA000_000F));
        vecs.push_back(mk(1, 1, 0, 7, 2, 'h3C, 0, 0, 1, 0, 0, 0, 8, 'hA000_0008));
        vecs.push_back(idle(8));
        // wrap-16 from word 31 -> 16
        vecs.push_back(mk(1, 1, 0, 2, 3, 'h7C, 0, 0, 0, 0, 1, 0, 31, 0));
        vecs.push_back(mk(1, 1, 0, 2, 3, 'h7C, 0, 0, 1, 0, 1, 0, 16, 'hA000_001F));
        vecs.push_back(mk(1, 1, 0, 7, 3, 'h7C, 0, 0, 1, 0, 0, 0, 16, 'hA000_0010));
        vecs.push_back(idle(16));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset waddr", 32'(sram_waddr), 0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d ack", i),   32'(wb_ack_o),   32'(vecs[i].e_ack));
            check($sformatf("v%0d err", i),   32'(wb_err_o),   32'(vecs[i].e_err));
            check($sformatf("v%0d ce", i),    32'(sram_ce),    32'(vecs[i].e_ce));
            check($sformatf("v%0d we", i),    32'(sram_we),    32'(vecs[i].e_we));
            check($sformatf("v%0d oe", i),    32'(sram_oe),    32'(vecs[i].e_ce & ~vecs[i].e_we));
            check($sformatf("v%0d waddr", i), 32'(sram_waddr), 32'(vecs[i].e_waddr));
            if (vecs[i].e_ack)
                check($sformatf("v%0d rdata", i), wb_dat_o, vecs[i].e_rd);
            if (vecs[i].e_we) begin
                check($sformatf("v%0d din", i), sram_din, vecs[i].dat);
                check($sformatf("v%0d sel", i), 32'(sram_sel), 32'(vecs[i].sel));
            end
        end

        // Reset asserted mid-burst, request held through reset and release.
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 2, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rb first ce", 32'(sram_ce), 1);
        check("rb first waddr", 32'(sram_waddr), 8);
        @(posedge clk);
        @(negedge clk);
        check("rb beat ack", 32'(wb_ack_o), 1);
        #2 rst = 1'b0;
        #1;
        check_quiet("rb async");
        check("rb async waddr", 32'(sram_waddr), 0);
        check("rb async rdata", wb_dat_o, 0);
        @(posedge clk);
        @(negedge clk);
        check_quiet("rb held");
        rst = 1'b1;
        #1;
        check_quiet("rb release");
        @(posedge clk); #1;
        drive(mk(1, 1, 0, 0, 0, 'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rr ce", 32'(sram_ce), 1);
        check("rr ack", 32'(wb_ack_o), 0);
        check("rr waddr", 32'(sram_waddr), 0);
        @(posedge clk);
        @(negedge clk);
        check("rr ack2", 32'(wb_ack_o), 1);
        check("rr rdata", wb_dat_o, 32'hA000_0000);
        check("rr ce2", 32'(sram_ce), 0);
        @(posedge clk); #1;
        drive(idle(0));
        @(negedge clk);
        check_quiet("rr idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
